// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and 8N1 frame constants for the word receiver
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int GAP_MAX_DEF    = 16;
  localparam int DATA_BITS      = 8;
  localparam int STOP_BITS      = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_word_if.sv
// rtl/uart_rx_word_if.sv - serial line and received-word signals between line side and receiver
interface uart_rx_word_if;
  logic        rx;
  logic [15:0] data;
  logic        valid;
  logic        framing_err;
  logic        busy;

  modport master (output rx, input data, valid, framing_err, busy);
  modport slave  (input rx, output data, valid, framing_err, busy);
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 2-FF rx synchronizer; UART_RX_MAJORITY_EN adds a 2-of-3 bit voter
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic rx_bit
);

  logic sync1;

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is the second synchronizer stage; hist[2:1] are the two previous samples
  logic [2:0] hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      hist  <= 3'b111;
    end else begin
      sync1 <= rx;
      hist  <= {hist[1:0], sync1};
    end
  end

  assign rx_s   = hist[0];
  assign rx_bit = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  logic sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rx_s   = sync2;
  assign rx_bit = sync2;
`endif

endmodule

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - 8N1 receiver assembling two bytes into a 16-bit word (UART_RX_MAJORITY_EN: voted bits)
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int GAP_MAX    = GAP_MAX_DEF
) (
  input  logic           clk_153k6hz,
  input  logic           reset,
  uart_rx_word_if.slave  bus
);

  localparam int TICK_W    = $clog2(OVERSAMPLE);
  localparam int GAP_LIMIT = GAP_MAX * OVERSAMPLE;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
`ifdef UART_RX_MAJORITY_EN
  // the vote completes one tick after the centre sample; all later decisions inherit that shift
  localparam logic [TICK_W-1:0] START_TICK = TICK_W'(OVERSAMPLE / 2);
`else
  localparam logic [TICK_W-1:0] START_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [TICK_W-1:0] BIT_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_LIMIT - 1);

  logic rx_s, rx_bit;

  uart_rx_sampler u_sampler (
    .clk    (clk_153k6hz),
    .reset  (reset),
    .rx     (bus.rx),
    .rx_s   (rx_s),
    .rx_bit (rx_bit)
  );

  rx_state_t         state, state_n;
  logic [TICK_W-1:0] tick, tick_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [7:0]        shreg, shreg_n, lo_byte, lo_n;
  logic              byte_idx, idx_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic [15:0]       data_q, data_n;
  logic              valid_q, valid_n, err_q, err_n;

  always_ff @(posedge clk_153k6hz or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      lo_byte  <= '0;
      byte_idx <= 1'b0;
      gap_cnt  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      tick     <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      lo_byte  <= lo_n;
      byte_idx <= idx_n;
      gap_cnt  <= gap_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick + 1'b1;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    lo_n    = lo_byte;
    idx_n   = byte_idx;
    gap_n   = gap_cnt;
    data_n  = data_q;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        tick_n = '0;
        if (!rx_s) state_n = ST_START;
      end
      ST_START: begin
        if (tick == START_TICK) begin
          tick_n = '0;
          bit_n  = '0;
          if (rx_bit) state_n = byte_idx ? ST_GAP : ST_IDLE;
          else        state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick == BIT_TICK) begin
          tick_n  = '0;
          shreg_n = {rx_bit, shreg[7:1]};
          if (bit_cnt == LAST_BIT) state_n = ST_STOP;
          else                     bit_n   = bit_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (tick == BIT_TICK) begin
          tick_n  = '0;
          idx_n   = 1'b0;
          state_n = ST_IDLE;
          if (!rx_bit) begin
            err_n = 1'b1;
          end else if (!byte_idx) begin
            lo_n    = shreg;
            idx_n   = 1'b1;
            gap_n   = '0;
            state_n = ST_GAP;
          end else begin
            data_n  = {shreg, lo_byte};
            valid_n = 1'b1;
          end
        end
      end
      ST_GAP: begin
        tick_n = '0;
        gap_n  = gap_cnt + 1'b1;
        // a start edge has priority over a timeout landing in the same cycle
        if (!rx_s) begin
          state_n = ST_START;
        end else if (gap_cnt == GAP_END) begin
          err_n   = 1'b1;
          idx_n   = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.data        = data_q;
  assign bus.valid       = valid_q;
  assign bus.framing_err = err_q;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_word.sv
// tb/tb_uart_rx_word.sv - randomized scoreboard bench for uart_rx_word
module tb_uart_rx_word;
  localparam int BIT_CYC = 16;

  logic clk_153k6hz = 1'b0;
  logic reset = 1'b1;
  uart_rx_word_if bus ();

  uart_rx_word dut (
    .clk_153k6hz (clk_153k6hz),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clk_153k6hz = ~clk_153k6hz;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_data = 16'h0000;
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: every output event must match the oldest outstanding expectation
  always @(negedge clk_153k6hz) begin
    if (!reset && (bus.valid || bus.framing_err)) begin
      check("valid_err_exclusive", 32'(bus.valid & bus.framing_err), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({bus.valid, bus.framing_err}), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.is_err ? "err_event_kind" : "valid_event_kind", 32'(bus.framing_err), 32'(e.is_err));
        check(e.is_err ? "data_held_on_err" : "word_data", 32'(bus.data), 32'(e.data));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_153k6hz);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    bus.rx = b;
    cyc(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) send_bit(b[i], BIT_CYC);
    send_bit(stop, BIT_CYC);
  endtask

  task automatic expect_word(input logic [7:0] b0, input logic [7:0] b1);
    exp_t e;
    model_data = {b1, b0};
    e.is_err = 1'b0;
    e.data   = model_data;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = model_data;
    exp_q.push_back(e);
  endtask

  task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1, input int gap_bits, input logic stop1);
    if (stop1) expect_word(b0, b1);
    else       expect_err();
    send_byte(b0, 1'b1);
    send_bit(1'b1, gap_bits * BIT_CYC);
    send_byte(b1, stop1);
    send_bit(1'b1, 2 * BIT_CYC);
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic send_zero_glitched();
    send_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, 8);
      send_bit(1'b1, 1);
      send_bit(1'b0, 7);
    end
    send_bit(1'b1, BIT_CYC);
  endtask
`endif

  initial begin
    bus.rx = 1'b1;
    cyc(3);
    check("reset_data", 32'(bus.data), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_err", 32'(bus.framing_err), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    send_bit(1'b1, 2 * BIT_CYC);

    send_pair(8'hA5, 8'h3C, 3, 1'b1);

    // short low pulse on idle line must be rejected as a false start
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    check("glitch_busy_in_start", 32'(bus.busy), 32'd1);
    send_bit(1'b1, 2 * BIT_CYC);
    check("glitch_busy_dropped", 32'(bus.busy), 32'd0);

    expect_err();
    send_byte(8'h55, 1'b0);
    send_bit(1'b1, 3 * BIT_CYC);

    expect_err();
    send_byte(8'h12, 1'b1);
    send_bit(1'b1, 17 * BIT_CYC);
    send_pair(8'h34, 8'h56, 1, 1'b1);

    // reset in the middle of byte 1, data bit 4
    send_byte(8'h77, 1'b1);
    send_bit(1'b1, 2 * BIT_CYC);
    send_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hAB >> i), BIT_CYC);
    send_bit(1'b0, 8);
    #2 reset = 1'b1;
    #1;
    check("midframe_reset_data", 32'(bus.data), 32'd0);
    check("midframe_reset_valid", 32'(bus.valid), 32'd0);
    check("midframe_reset_err", 32'(bus.framing_err), 32'd0);
    check("midframe_reset_busy", 32'(bus.busy), 32'd0);
    model_data = 16'h0000;
    bus.rx = 1'b1;
    cyc(3);
    reset = 1'b0;
    send_bit(1'b1, BIT_CYC);
    send_pair(8'hFF, 8'h00, 0, 1'b1);

    for (int n = 0; n < 16; n++) begin
      logic [7:0] b0, b1;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        expect_err();
        send_byte(b0, 1'b0);
        send_bit(1'b1, 3 * BIT_CYC);
      end
      send_pair(b0, b1, int'($urandom_range(0, 12)), $urandom_range(0, 4) != 0);
    end

`ifdef UART_RX_MAJORITY_EN
    expect_word(8'h00, 8'h00);
    send_zero_glitched();
    send_bit(1'b1, 2 * BIT_CYC);
    send_zero_glitched();
    send_bit(1'b1, 2 * BIT_CYC);
`endif

    send_bit(1'b1, 4 * BIT_CYC);
    check("all_events_seen", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
